// File: rtl/ripple_down_timer.sv
// Programmable down-counter/timer: load, start/stop/resume, count on en ticks, one-cycle tc at zero.
// Optional AUTO_RELOAD_EN: periodic mode that reloads from the captured load value instead of stopping.
module ripple_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_val;
    end
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every branch below
  // sees the pre-edge values of state and q, matching the register semantics.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      q     <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        q     <= load_val;
        state <= IDLE;
      end else if (stop) begin
        // stop consumes the edge: it pauses a running count and masks start.
        if (state == RUN) state <= PAUSE;
      end else if (start && state != RUN) begin
        if (q != '0) state <= RUN;
      end else if (state == RUN && en) begin
        if (q == WIDTH'(1)) begin
          q  <= '0;
          tc <= 1'b1;
`ifndef AUTO_RELOAD_EN
          state <= DONE;
`endif
        end else if (q == '0) begin
`ifdef AUTO_RELOAD_EN
          q <= reload;
`endif
        end else begin
          q <= q - WIDTH'(1);
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ripple_down_timer.sv
// Directed self-checking bench for ripple_down_timer (WIDTH=4); one task per scenario.
// Define AUTO_RELOAD_EN for both RTL and bench to exercise periodic mode.
module tb_ripple_down_timer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       load, start, stop, en;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       busy, done, tc;

  int checks = 0;
  int errors = 0;

  ripple_down_timer #(.WIDTH(4)) dut (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .en(en),
    .q(q), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load = 0; start = 0; stop = 0; en = 0; load_val = '0;
  endtask

  task automatic do_load(input logic [3:0] v);
    idle_inputs();
    load = 1; load_val = v;
    tick();
    load = 0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    idle_inputs();
    rstn = 0;
    #2;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_initial: got %b want %b (busy,done,tc,q)", obs, 7'b000_0000);
    end
    tick();
    rstn = 1;
    tick();
    do_load(4'd6);
    start = 1;
    tick();
    start = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b100, 4'd6}) begin
      errors++;
      $display("FAIL reset_prerun: got %b want %b", obs, {3'b100, 4'd6});
    end
    // Assert reset mid-cycle: outputs must clear without waiting for an edge.
    #2 rstn = 0;
    #1;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL reset_async: got %b want %b", obs, 7'b000_0000);
    end
    tick();
    rstn = 1;
    en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {busy, done, tc, q};
      checks++;
      if (obs !== 7'b000_0000) begin
        errors++;
        $display("FAIL reset_stays_idle[%0d]: got %b want %b", i, obs, 7'b000_0000);
      end
    end
    idle_inputs();
  endtask

`ifndef AUTO_RELOAD_EN
  task automatic test_one_shot();
    logic [6:0] obs, exp;
    do_load(4'd5);
    start = 1; en = 1;
    tick();
    start = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b100, 4'd5}) begin
      errors++;
      $display("FAIL one_shot_start: got %b want %b", obs, {3'b100, 4'd5});
    end
    for (int i = 4; i >= 0; i--) begin
      tick();
      exp = (i == 0) ? {3'b011, 4'd0} : {3'b100, 4'(i)};
      obs = {busy, done, tc, q};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL one_shot_q%0d: got %b want %b", i, obs, exp);
      end
    end
    tick();
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b010, 4'd0}) begin
      errors++;
      $display("FAIL one_shot_after: got %b want %b", obs, {3'b010, 4'd0});
    end
    idle_inputs();
  endtask

  task automatic test_gated_en();
    logic [6:0] obs, exp;
    logic [3:0] model;
    do_load(4'd4);
    start = 1;
    tick();
    start = 0;
    model = 4'd4;
    for (int i = 0; i < 12; i++) begin
      en = (i % 3 == 2);
      tick();
      if (en) model = model - 4'd1;
      if (model == 0 && en) exp = {3'b011, 4'd0};
      else if (model == 0)  exp = {3'b010, 4'd0};
      else                  exp = {3'b100, model};
      obs = {busy, done, tc, q};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL gated_en[%0d]: got %b want %b", i, obs, exp);
      end
    end
    idle_inputs();
  endtask
`else
  task automatic test_auto_reload();
    logic [6:0] obs, exp;
    logic [3:0] seq [8] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0, 4'd3};
    do_load(4'd3);
    start = 1; en = 1;
    tick();
    start = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b100, 4'd3}) begin
      errors++;
      $display("FAIL auto_start: got %b want %b", obs, {3'b100, 4'd3});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {2'b10, (seq[i] == 4'd0), seq[i]};
      obs = {busy, done, tc, q};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL auto_reload[%0d]: got %b want %b", i, obs, exp);
      end
    end
    idle_inputs();
  endtask
`endif

  task automatic test_pause_resume();
    logic [6:0] obs;
    do_load(4'd5);
    start = 1;
    tick();
    start = 0; en = 1;
    tick();
    tick();
    stop = 1;
    tick();
    stop = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b000, 4'd3}) begin
      errors++;
      $display("FAIL pause_enter: got %b want %b", obs, {3'b000, 4'd3});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (q !== 4'd3 || busy !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got q=%0d busy=%b want q=3 busy=0", i, q, busy);
      end
    end
    start = 1;
    tick();
    start = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b100, 4'd3}) begin
      errors++;
      $display("FAIL resume_start: got %b want %b", obs, {3'b100, 4'd3});
    end
    tick();
    checks++;
    if (q !== 4'd2) begin
      errors++;
      $display("FAIL resume_first_tick: got q=%0d want q=2", q);
    end
    en = 0;
  endtask

  task automatic test_priority();
    logic [6:0] obs;
    // Entered while RUN with q=2 from the pause/resume scenario.
    load = 1; load_val = 4'd9; start = 1; en = 1;
    tick();
    load = 0; start = 0; en = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b000, 4'd9}) begin
      errors++;
      $display("FAIL prio_load_start: got %b want %b", obs, {3'b000, 4'd9});
    end
    start = 1;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_start_run: got busy=%b want busy=1", busy);
    end
    stop = 1; start = 1;
    tick();
    stop = 0; start = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== {3'b000, 4'd9}) begin
      errors++;
      $display("FAIL prio_stop_start: got %b want %b", obs, {3'b000, 4'd9});
    end
    do_load(4'd0);
    start = 1; en = 1;
    tick();
    start = 0; en = 0;
    obs = {busy, done, tc, q};
    checks++;
    if (obs !== 7'b000_0000) begin
      errors++;
      $display("FAIL prio_start_zero: got %b want %b", obs, 7'b000_0000);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
`ifndef AUTO_RELOAD_EN
    test_one_shot();
`else
    test_auto_reload();
`endif
    test_pause_resume();
    test_priority();
`ifndef AUTO_RELOAD_EN
    test_gated_en();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
